// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: pipeline status inputs, stage-register enables,
// flushes, PC select and debug/performance outputs. These are plain level
// signals sampled and produced every cycle; there is no valid/ready
// handshake, and the outputs are meaningful on every cycle.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) ();
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt_dest;
  logic             mem_branch_taken;
  logic             mem_access;
  logic             mem_ready;
  logic             halt_req;
  logic             step_req;

  logic             pc_we;
  logic             if_id_we;
  logic             id_ex_we;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mem_wb_flush;
  logic             pc_sel_branch;
  logic [1:0]       state;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side: drives status, observes controls.
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt_dest,
           mem_branch_taken, mem_access, mem_ready, halt_req, step_req,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           pc_sel_branch, state, halted, mem_timeout, stall_cycles, flush_count
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt_dest,
           mem_branch_taken, mem_access, mem_ready, halt_req, step_req,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           pc_sel_branch, state, halted, mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, taken-branch
// flushes, data-memory wait freezing with timeout, and debug halt/step.
// Controls are combinational from state and inputs; state and counters
// are registered.
module pipeline_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2,
    STEP     = 2'd3
  } state_t;

  state_t            state_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  flush_q;

  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  ex_rt_dest;
  logic              w;
  logic              b;
  logic              h;

  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic pc_sel_branch;

  assign id_rs      = bus.id_rs;
  assign id_rt      = bus.id_rt;
  assign ex_rt_dest = bus.ex_rt_dest;

  // A memory wait freezes everything; register $zero never causes a load-use stall.
  assign w = bus.mem_access & ~bus.mem_ready;
  assign b = bus.mem_branch_taken;
  assign h = bus.ex_mem_read & (ex_rt_dest != '0) &
             ((ex_rt_dest == id_rs) | (bus.id_uses_rt & (ex_rt_dest == id_rt)));

  // Control outputs: reset bubbles the pipe, HALTED freezes it, otherwise W > B > H > none.
  always_comb begin
    pc_we         = 1'b0;
    if_id_we      = 1'b0;
    id_ex_we      = 1'b0;
    ex_mem_we     = 1'b0;
    mem_wb_we     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    pc_sel_branch = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (state_q != HALTED) begin
      if (w) begin
        mem_wb_flush = 1'b1;
      end else if (b) begin
        pc_we         = 1'b1;
        if_id_we      = 1'b1;
        id_ex_we      = 1'b1;
        ex_mem_we     = 1'b1;
        mem_wb_we     = 1'b1;
        pc_sel_branch = 1'b1;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        ex_mem_flush  = 1'b1;
      end else if (h) begin
        id_ex_we    = 1'b1;
        ex_mem_we   = 1'b1;
        mem_wb_we   = 1'b1;
        id_ex_flush = 1'b1;
      end else begin
        pc_we     = 1'b1;
        if_id_we  = 1'b1;
        id_ex_we  = 1'b1;
        ex_mem_we = 1'b1;
        mem_wb_we = 1'b1;
      end
    end
  end

  // Control FSM with memory-wait counter; the entering wait cycle counts as the first one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (w) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= WAIT_W'(1);
          end else if (bus.halt_req) begin
            state_q <= HALTED;
          end
        end
        MEM_WAIT: begin
          if (w) begin
            if (wait_cnt_q == WAIT_LAST) begin
              timeout_q  <= 1'b1;
              wait_cnt_q <= '0;
              state_q    <= HALTED;
            end else begin
              wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end
          end else begin
            wait_cnt_q <= '0;
            state_q    <= bus.halt_req ? HALTED : RUN;
          end
        end
        HALTED: begin
          if (!bus.halt_req) begin
            state_q <= RUN;
          end else if (bus.step_req) begin
            state_q <= STEP;
          end
        end
        STEP: begin
          if (w) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= WAIT_W'(1);
          end else begin
            state_q <= HALTED;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Saturating performance counters for stalled cycles and taken-branch redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_we && (state_q != HALTED) && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (pc_sel_branch && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc_we         = pc_we;
  assign bus.if_id_we      = if_id_we;
  assign bus.id_ex_we      = id_ex_we;
  assign bus.ex_mem_we     = ex_mem_we;
  assign bus.mem_wb_we     = mem_wb_we;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.ex_mem_flush  = ex_mem_flush;
  assign bus.mem_wb_flush  = mem_wb_flush;
  assign bus.pc_sel_branch = pc_sel_branch;
  assign bus.state         = state_q;
  assign bus.halted        = (state_q == HALTED);
  assign bus.mem_timeout   = timeout_q;
  assign bus.stall_cycles  = stall_q;
  assign bus.flush_count   = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic,
// each cycle's expected outputs come from a behavioural model and are
// queued; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;
  localparam int REG_W    = 5;
  localparam int MAX_WAIT = 16;
  localparam int CNT_W    = 16;
  localparam int EXP_W    = 14 + 2 * CNT_W;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.REG_W(REG_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // staged stimulus
  logic             s_rst;
  logic [REG_W-1:0] s_rs, s_rt, s_dest;
  logic             s_urt, s_mr, s_br, s_acc, s_rdy, s_halt, s_step;

  // reference model: mode 0 running, 1 waiting on memory, 2 halted, 3 stepping
  int m_mode;
  int m_wait_len;
  bit m_timeout;
  int m_stall;
  int m_flush;

  function automatic logic [EXP_W-1:0] pack(input bit [4:0] we, input bit [3:0] fl,
                                            input bit ps, input int mode, input bit tmo,
                                            input int stall, input int fc);
    return {we, fl, ps, 2'(mode), (mode == 2), tmo, CNT_W'(stall), CNT_W'(fc)};
  endfunction

  // Expected outputs for the cycle now on the inputs, then advance the model.
  task automatic model_cycle();
    bit w, b, h, ps;
    bit [4:0] we;  // pc, if_id, id_ex, ex_mem, mem_wb
    bit [3:0] fl;  // if_id, id_ex, ex_mem, mem_wb
    we = '0;
    fl = '0;
    ps = 1'b0;
    if (s_rst) begin
      m_mode = 0; m_wait_len = 0; m_timeout = 0; m_stall = 0; m_flush = 0;
      exp_q.push_back(pack(5'b00000, 4'b1111, 1'b0, 0, 1'b0, 0, 0));
      return;
    end
    w = s_acc && !s_rdy;
    b = s_br;
    h = s_mr && (s_dest != 0) && ((s_dest == s_rs) || (s_urt && (s_dest == s_rt)));
    if (m_mode != 2) begin
      if (w)      fl = 4'b0001;
      else if (b) begin we = 5'b11111; ps = 1'b1; fl = 4'b1110; end
      else if (h) begin we = 5'b00111; fl = 4'b0100; end
      else        we = 5'b11111;
    end
    exp_q.push_back(pack(we, fl, ps, m_mode, m_timeout, m_stall, m_flush));
    if (!we[4] && (m_mode != 2) && (m_stall < CNT_MAX)) m_stall++;
    if (ps && (m_flush < CNT_MAX)) m_flush++;
    case (m_mode)
      0: if (w) begin m_mode = 1; m_wait_len = 1; end
         else if (s_halt) m_mode = 2;
      1: if (w) begin
           m_wait_len++;
           if (m_wait_len >= MAX_WAIT) begin m_timeout = 1; m_wait_len = 0; m_mode = 2; end
         end else begin
           m_wait_len = 0;
           m_mode = s_halt ? 2 : 0;
         end
      2: if (!s_halt) m_mode = 0;
         else if (s_step) m_mode = 3;
      default: if (w) begin m_mode = 1; m_wait_len = 1; end
               else m_mode = 2;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    s_rst = 0; s_rs = '0; s_rt = '0; s_dest = '0; s_urt = 0; s_mr = 0;
    s_br = 0; s_acc = 0; s_rdy = 1; s_halt = 0; s_step = 0;
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
    rst                  = s_rst;
    bus.id_rs            = s_rs;
    bus.id_rt            = s_rt;
    bus.id_uses_rt       = s_urt;
    bus.ex_mem_read      = s_mr;
    bus.ex_rt_dest       = s_dest;
    bus.mem_branch_taken = s_br;
    bus.mem_access       = s_acc;
    bus.mem_ready        = s_rdy;
    bus.halt_req         = s_halt;
    bus.step_req         = s_step;
    model_cycle();
  endtask

  task automatic do_reset();
    idle();
    s_rst = 1;
    step_cycle();
    step_cycle();
    s_rst = 0;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we,
               bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush,
               bus.pc_sel_branch, bus.state, bus.halted, bus.mem_timeout,
               bus.stall_cycles, bus.flush_count};
      n_checks++;
      if (act_v !== exp_v) begin
        n_errors++;
        $display("FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, act_v, exp_v);
      end
    end
  end

  function automatic logic [4:0] we_vec();
    return {bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we, bus.mem_wb_we};
  endfunction

  function automatic logic [3:0] fl_vec();
    return {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int pc_ones;
    bit slow;
    rst = 1'b1;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 0; bus.ex_mem_read = 0;
    bus.ex_rt_dest = '0; bus.mem_branch_taken = 0; bus.mem_access = 0;
    bus.mem_ready = 1; bus.halt_req = 0; bus.step_req = 0;
    do_reset();

    // load-use stall on rs
    idle(); s_mr = 1; s_dest = 5'd22; s_rs = 5'd22; s_rt = 5'd5;
    step_cycle(); @(negedge clk);
    chk("load_use_pc_we", bus.pc_we, 0);
    chk("load_use_if_id_we", bus.if_id_we, 0);
    chk("load_use_id_ex_flush", bus.id_ex_flush, 1);
    chk("load_use_we_vec", we_vec(), 5'b00111);
    idle(); step_cycle(); @(negedge clk);
    chk("load_use_stall_cnt", bus.stall_cycles, 1);
    chk("load_use_released", bus.pc_we, 1);

    // rt match only counts when the ID instruction reads rt
    idle(); s_mr = 1; s_dest = 5'd7; s_rt = 5'd7; s_rs = 5'd3; s_urt = 0;
    step_cycle(); @(negedge clk);
    chk("rt_unused_no_stall", bus.pc_we, 1);
    s_urt = 1; step_cycle(); @(negedge clk);
    chk("rt_used_stall", bus.pc_we, 0);

    // $zero exemption
    do_reset();
    idle(); s_mr = 1; s_dest = '0; s_rs = '0; s_rt = '0; s_urt = 1;
    step_cycle(); @(negedge clk);
    chk("zero_exempt_we", we_vec(), 5'b11111);
    chk("zero_exempt_flush", fl_vec(), 4'b0000);

    // branch held during a memory wait
    do_reset();
    idle(); s_br = 1; s_acc = 1; s_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step_cycle(); @(negedge clk);
      chk("br_wait_we", we_vec(), 5'b00000);
      chk("br_wait_pc_sel", bus.pc_sel_branch, 0);
      chk("br_wait_flush", fl_vec(), 4'b0001);
    end
    s_rdy = 1; step_cycle(); @(negedge clk);
    chk("br_release_pc_sel", bus.pc_sel_branch, 1);
    chk("br_release_flush", fl_vec(), 4'b1110);
    chk("br_release_we", we_vec(), 5'b11111);
    idle(); step_cycle(); @(negedge clk);
    chk("br_flush_count", bus.flush_count, 1);
    chk("br_state_run", bus.state, 0);

    // memory timeout after MAX_WAIT waiting cycles
    do_reset();
    idle(); s_acc = 1; s_rdy = 0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      step_cycle(); @(negedge clk);
      chk("timeout_not_yet", bus.mem_timeout, 0);
      chk("timeout_wait_state", bus.state, (i == 0) ? 0 : 1);
    end
    idle(); step_cycle(); @(negedge clk);
    chk("timeout_flag", bus.mem_timeout, 1);
    chk("timeout_halted_state", bus.state, 2);
    chk("timeout_halted_flag", bus.halted, 1);
    chk("timeout_halted_we", we_vec(), 5'b00000);
    step_cycle(); @(negedge clk);
    chk("timeout_back_to_run", bus.state, 0);
    chk("timeout_sticky", bus.mem_timeout, 1);
    step_cycle(); @(negedge clk);
    chk("timeout_sticky_later", bus.mem_timeout, 1);

    // halt and single step
    do_reset();
    idle(); s_halt = 1;
    step_cycle(); @(negedge clk);
    pc_ones = 0;
    step_cycle(); @(negedge clk);
    pc_ones += int'(bus.pc_we);
    chk("halted_state", bus.state, 2);
    s_step = 1; step_cycle(); @(negedge clk);
    pc_ones += int'(bus.pc_we);
    s_step = 0;
    for (int i = 0; i < 3; i++) begin
      step_cycle(); @(negedge clk);
      pc_ones += int'(bus.pc_we);
    end
    chk("step_one_cycle", pc_ones, 1);
    chk("step_back_halted", bus.state, 2);
    s_halt = 0; step_cycle(); @(negedge clk);
    step_cycle(); @(negedge clk);
    chk("unhalt_run", bus.state, 0);

    // reset in the middle of a memory wait
    do_reset();
    idle(); s_acc = 1; s_rdy = 0;
    for (int i = 0; i < 4; i++) step_cycle();
    @(negedge clk);
    chk("pre_reset_wait", bus.state, 1);
    s_rst = 1; step_cycle(); #1;
    chk("async_rst_we", we_vec(), 5'b00000);
    chk("async_rst_flush", fl_vec(), 4'b1111);
    chk("async_rst_pc_sel", bus.pc_sel_branch, 0);
    chk("async_rst_state", bus.state, 0);
    step_cycle();
    idle(); step_cycle(); @(negedge clk);
    chk("post_rst_state", bus.state, 0);
    chk("post_rst_stall", bus.stall_cycles, 0);
    chk("post_rst_flush", bus.flush_count, 0);
    chk("post_rst_timeout", bus.mem_timeout, 0);

    // randomized traffic against the model
    do_reset();
    idle();
    slow = 0;
    for (int i = 0; i < 2000; i++) begin
      s_rst  = ($urandom_range(0, 299) == 0);
      s_rs   = REG_W'($urandom_range(0, 3));
      s_rt   = REG_W'($urandom_range(0, 3));
      s_dest = REG_W'($urandom_range(0, 3));
      s_urt  = 1'($urandom_range(0, 1));
      s_mr   = 1'($urandom_range(0, 1));
      s_br   = ($urandom_range(0, 3) == 0);
      s_acc  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) slow = ~slow;
      s_rdy  = ($urandom_range(0, 9) < (slow ? 1 : 7));
      if ($urandom_range(0, 24) == 0) s_halt = ~s_halt;
      s_step = ($urandom_range(0, 3) == 0);
      step_cycle();
    end

    idle();
    step_cycle();
    step_cycle();
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
